ball_rally_controller: RTL

// Sequences the horizontal ball datapath through a pong rally. Watches ball and

---
 rtl/ball_rally_controller_pkg.sv | 33 +++
 rtl/ball_rally_controller_blank_edge_detect.sv | 39 +++
 rtl/ball_rally_controller.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ball_rally_controller_pkg.sv
// ----------------------------------------------------------------------------
// ball_rally_controller_pkg
// Shared definitions for the pong rally controller: FSM state encoding,
// ball direction values, score width and small helper functions.
// ----------------------------------------------------------------------------
package ball_rally_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SERVE     = 3'd1,
        ST_PLAY      = 3'd2,
        ST_SCORED    = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_e;

    // Direction encoding seen by the horizontal ball datapath.
    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    localparam int SCORE_W = 4;

    // Bits needed for a counter that runs 0 .. max_count-1.
    function automatic int cnt_width(input int max_count);
        return (max_count < 2) ? 1 : $clog2(max_count);
    endfunction

    // Score increment that holds at the winning score instead of wrapping.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] score,
                                                   input logic [SCORE_W-1:0] limit);
        return (score >= limit) ? score : score + SCORE_W'(1);
    endfunction

endpackage

// File: rtl/ball_rally_controller_blank_edge_detect.sv
// ----------------------------------------------------------------------------
// blank_edge_detect
// Registers one blanking signal and reports its rising and falling edges.
// The pulses are valid in the cycle the new level is first seen on i_Blank.
//   i_Clk    pixel clock
//   i_Rst_n  asynchronous active-low reset
//   i_Blank  blanking input (HBlank or VBlank)
//   o_Rise   i_Blank is 1 now and was 0 last cycle
//   o_Fall   i_Blank is 0 now and was 1 last cycle
// ----------------------------------------------------------------------------
module blank_edge_detect (
    input  logic i_Clk,
    input  logic i_Rst_n,
    input  logic i_Blank,
    output logic o_Rise,
    output logic o_Fall
);

    logic blank_d;
    logic blank_q;

    always_comb begin
        blank_d = i_Blank;
    end

    // NOTE: sequential state uses non-blocking assignment so every flop samples
    // the pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            blank_q <= 1'b0;
        end else begin
            blank_q <= blank_d;
        end
    end

    assign o_Rise = i_Blank & ~blank_q;
    assign o_Fall = ~i_Blank & blank_q;

endmodule

// File: rtl/ball_rally_controller.sv
// ----------------------------------------------------------------------------
// ball_rally_controller
// Sequences a pong rally. Ball/paddle video is watched during each frame and
// condensed into sticky flags; once per frame (VBlank rise) the FSM decides
// bounce, point or game end. All outputs are registered.
//   i_Clk, i_Rst_n      pixel clock, asynchronous active-low reset
//   i_HBlank, i_VBlank  blanking from the VGA timing generator
//   i_Ball_Video        ball pixel on
//   i_Paddle_L_Video    left paddle pixel on
//   i_Paddle_R_Video    right paddle pixel on
//   i_Start             level, starts a game from IDLE or GAME_OVER
//   o_HDir              ball direction (0 right, 1 left)
//   o_Ball_Move         ball position may advance
//   o_Ball_Visible      ball video enable
//   o_Recenter          one-cycle pulse on entering SERVE
//   o_Score_L/R         player scores
//   o_Game_Over         high in GAME_OVER
// ----------------------------------------------------------------------------
module ball_rally_controller
    import ball_rally_controller_pkg::*;
#(
    parameter int p_SERVE_FRAMES = 60,
    parameter int p_SCORE_FRAMES = 90,
    parameter int p_WIN_SCORE    = 9
) (
    input  logic               i_Clk,
    input  logic               i_Rst_n,
    input  logic               i_HBlank,
    input  logic               i_VBlank,
    input  logic               i_Ball_Video,
    input  logic               i_Paddle_L_Video,
    input  logic               i_Paddle_R_Video,
    input  logic               i_Start,
    output logic               o_HDir,
    output logic               o_Ball_Move,
    output logic               o_Ball_Visible,
    output logic               o_Recenter,
    output logic [SCORE_W-1:0] o_Score_L,
    output logic [SCORE_W-1:0] o_Score_R,
    output logic               o_Game_Over
);

    localparam int CNT_MAX = (p_SERVE_FRAMES > p_SCORE_FRAMES) ? p_SERVE_FRAMES
                                                               : p_SCORE_FRAMES;
    localparam int CNT_W   = cnt_width(CNT_MAX);

    localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(p_SERVE_FRAMES - 1);
    localparam logic [CNT_W-1:0]   SCORE_LAST = CNT_W'(p_SCORE_FRAMES - 1);
    localparam logic [SCORE_W-1:0] WIN_SCORE  = SCORE_W'(p_WIN_SCORE);

    // ------------------------------------------------------------------
    // Blank edge detection
    // ------------------------------------------------------------------
    logic hblank_rise;
    logic hblank_fall;
    logic frame_tick;
    logic vblank_fall_unused;

    blank_edge_detect u_hblank_edge (
        .i_Clk   (i_Clk),
        .i_Rst_n (i_Rst_n),
        .i_Blank (i_HBlank),
        .o_Rise  (hblank_rise),
        .o_Fall  (hblank_fall)
    );

    blank_edge_detect u_vblank_edge (
        .i_Clk   (i_Clk),
        .i_Rst_n (i_Rst_n),
        .i_Blank (i_VBlank),
        .o_Rise  (frame_tick),
        .o_Fall  (vblank_fall_unused)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e             state_d,     state_q;
    logic [CNT_W-1:0]   cnt_d,       cnt_q;
    logic               hdir_d,      hdir_q;
    logic               move_d,      move_q;
    logic               visible_d,   visible_q;
    logic               recenter_d,  recenter_q;
    logic               game_over_d, game_over_q;
    logic [SCORE_W-1:0] score_l_d,   score_l_q;
    logic [SCORE_W-1:0] score_r_d,   score_r_q;
    logic               hit_l_d,     hit_l_q;
    logic               hit_r_d,     hit_r_q;
    logic               edge_l_d,    edge_l_q;
    logic               edge_r_d,    edge_r_q;
    logic               ball_prev_d, ball_prev_q;

    logic hit_l_ev;
    logic hit_r_ev;
    logic edge_l_ev;
    logic edge_r_ev;

    // Ball leaving the right side is seen one cycle late: HBlank rises the
    // cycle after the last active pixel, so the previous ball video is used.
    assign hit_l_ev  = i_Ball_Video & i_Paddle_L_Video;
    assign hit_r_ev  = i_Ball_Video & i_Paddle_R_Video;
    assign edge_l_ev = hblank_fall & i_Ball_Video;
    assign edge_r_ev = hblank_rise & ball_prev_q;

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hdir_d      = hdir_q;
        score_l_d   = score_l_q;
        score_r_d   = score_r_q;
        ball_prev_d = i_Ball_Video;
        recenter_d  = 1'b0;

        // Flags collect a whole frame of PLAY video and are consumed by the tick.
        if (frame_tick) begin
            hit_l_d  = 1'b0;
            hit_r_d  = 1'b0;
            edge_l_d = 1'b0;
            edge_r_d = 1'b0;
        end else if (state_q == ST_PLAY) begin
            hit_l_d  = hit_l_q  | hit_l_ev;
            hit_r_d  = hit_r_q  | hit_r_ev;
            edge_l_d = edge_l_q | edge_l_ev;
            edge_r_d = edge_r_q | edge_r_ev;
        end else begin
            hit_l_d  = hit_l_q;
            hit_r_d  = hit_r_q;
            edge_l_d = edge_l_q;
            edge_r_d = edge_r_q;
        end

        unique case (state_q)
            ST_IDLE, ST_GAME_OVER: begin
                if (i_Start) begin
                    state_d   = ST_SERVE;
                    score_l_d = '0;
                    score_r_d = '0;
                    hdir_d    = DIR_RIGHT;
                end
            end

            ST_SERVE: begin
                if (frame_tick) begin
                    if (cnt_q == SERVE_LAST) begin
                        state_d = ST_PLAY;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            ST_PLAY: begin
                // A paddle hit outranks an edge in the same frame; only the
                // paddle the ball is travelling toward counts.
                if (frame_tick) begin
                    if (hit_r_q && hdir_q == DIR_RIGHT) begin
                        hdir_d = DIR_LEFT;
                    end else if (hit_l_q && hdir_q == DIR_LEFT) begin
                        hdir_d = DIR_RIGHT;
                    end else if (edge_r_q && hdir_q == DIR_RIGHT) begin
                        score_l_d = sat_inc(score_l_q, WIN_SCORE);
                        state_d   = ST_SCORED;
                    end else if (edge_l_q && hdir_q == DIR_LEFT) begin
                        score_r_d = sat_inc(score_r_q, WIN_SCORE);
                        state_d   = ST_SCORED;
                    end
                end
            end

            ST_SCORED: begin
                // hdir is left untouched: it still points at the player who
                // missed, which is where the next serve goes.
                if (frame_tick) begin
                    if (cnt_q == SCORE_LAST) begin
                        if (score_l_q == WIN_SCORE || score_r_q == WIN_SCORE) begin
                            state_d = ST_GAME_OVER;
                        end else begin
                            state_d = ST_SERVE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
            if (state_d == ST_SERVE) begin
                recenter_d = 1'b1;
            end
        end

        // Outputs are decoded from the next state so they change on the same
        // edge as the state register.
        visible_d   = (state_d == ST_SERVE) || (state_d == ST_PLAY);
        move_d      = (state_d == ST_PLAY);
        game_over_d = (state_d == ST_GAME_OVER);
    end

    // NOTE: all state, including the sticky flags, is cleared by the
    // asynchronous reset so a mid-game reset leaves nothing pending.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            hdir_q      <= DIR_RIGHT;
            move_q      <= 1'b0;
            visible_q   <= 1'b0;
            recenter_q  <= 1'b0;
            game_over_q <= 1'b0;
            score_l_q   <= '0;
            score_r_q   <= '0;
            hit_l_q     <= 1'b0;
            hit_r_q     <= 1'b0;
            edge_l_q    <= 1'b0;
            edge_r_q    <= 1'b0;
            ball_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hdir_q      <= hdir_d;
            move_q      <= move_d;
            visible_q   <= visible_d;
            recenter_q  <= recenter_d;
            game_over_q <= game_over_d;
            score_l_q   <= score_l_d;
            score_r_q   <= score_r_d;
            hit_l_q     <= hit_l_d;
            hit_r_q     <= hit_r_d;
            edge_l_q    <= edge_l_d;
            edge_r_q    <= edge_r_d;
            ball_prev_q <= ball_prev_d;
        end
    end

    assign o_HDir         = hdir_q;
    assign o_Ball_Move    = move_q;
    assign o_Ball_Visible = visible_q;
    assign o_Recenter     = recenter_q;
    assign o_Score_L      = score_l_q;
    assign o_Score_R      = score_r_q;
    assign o_Game_Over    = game_over_q;

endmodule
